fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH/LOAD/EXEC per instruction, with PC update,
// saturating executed-instruction counter and a sticky HALT left only by reset.
module fetch_unit #(
    parameter int PC_W = 10,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            s_inc,
    input  logic            fin,
    input  logic [IW-1:0]   mem_rdata,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_en,
    output logic [5:0]      opcode,
    output logic [PC_W-1:0] jaddr,
    output logic            exec,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     icount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t        state;
    logic [IW-1:0] ir;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign mem_addr = pc;
    assign opcode   = ir[IW-1:IW-6];
    assign jaddr    = ir[PC_W-1:0];

    // mem_en/exec/halted are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= '0;
            ir     <= '0;
            icount <= '0;
            mem_en <= 1'b0;
            exec   <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state  <= FETCH;
                        mem_en <= 1'b1;
                    end
                end
                FETCH: begin
                    state  <= LOAD;
                    mem_en <= 1'b0;
                end
                LOAD: begin
                    ir    <= mem_rdata;
                    state <= EXEC;
                    exec  <= 1'b1;
                end
                EXEC: begin
                    exec   <= 1'b0;
                    icount <= sat_inc(icount);
                    if (fin) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= s_inc ? pc + 1'b1 : ir[PC_W-1:0];
                        if (run) begin
                            state  <= FETCH;
                            mem_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                    mem_en <= 1'b0;
                    exec   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    exec   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model, a small control-unit model, and a
// scoreboard of expected fetch addresses and executed instructions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        s_inc;
    logic        fin;
    logic [15:0] mem_rdata = '0;
    logic [9:0]  mem_addr;
    logic        mem_en;
    logic [5:0]  opcode;
    logic [9:0]  jaddr;
    logic        exec;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] icount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fetch = -100;
    logic noise = 1'b0;
    logic [15:0] mem [0:1023];
    logic [9:0]  fetch_q [$];
    logic [15:0] exec_q [$];

    fetch_unit #(.PC_W(10), .IW(16)) dut (
        .clk(clk), .reset(reset), .run(run), .s_inc(s_inc), .fin(fin),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_en(mem_en),
        .opcode(opcode), .jaddr(jaddr), .exec(exec), .pc(pc),
        .halted(halted), .icount(icount)
    );

    always #5 clk = ~clk;

    // Control-unit model: opcode 9 jumps, opcode 3F halts; junk outside EXEC
    assign s_inc = exec ? (opcode != 6'h09) : noise;
    assign fin   = exec ? (opcode == 6'h3F) : noise;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= ~noise;
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops scoreboard whenever the DUT presents a fetch or an exec
    always @(negedge clk) begin
        if (mem_en) begin
            if (fetch_q.size() == 0) chk("unexpected_fetch", {22'd0, mem_addr}, 32'hFFFF);
            else chk("fetch_addr", {22'd0, mem_addr}, {22'd0, fetch_q.pop_front()});
            last_fetch = cyc;
        end
        if (exec) begin
            if (exec_q.size() == 0) chk("unexpected_exec", {16'd0, opcode, jaddr}, 32'hFFFF);
            else chk("exec_inst", {16'd0, opcode, jaddr}, {16'd0, exec_q.pop_front()});
            chk("exec_latency", cyc - last_fetch, 2);
        end
    end

    task automatic wait_halt(input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (halted) begin seen = 1'b1; break; end
        end
        chk(nm, {31'd0, seen}, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {22'd0, pc}, 0);
        chk("rst_icount", {16'd0, icount}, 0);
        chk("rst_outs", {16'd0, opcode, jaddr}, 0);
        chk("rst_flags", {29'd0, exec, mem_en, halted}, 0);

        // Sequential, jump and halt program
        mem[0] = 16'h0401; mem[1] = 16'h0802; mem[2] = 16'h0C03;
        mem[3] = 16'h2405; mem[5] = 16'h1406; mem[6] = 16'h1807;
        mem[7] = 16'hFC00;
        fetch_q = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5, 10'd6, 10'd7};
        exec_q  = '{16'h0401, 16'h0802, 16'h0C03, 16'h2405, 16'h1406, 16'h1807, 16'hFC00};
        @(negedge clk) reset = 1'b1;
        @(negedge clk) run = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("seq_icount", {16'd0, icount}, 3);
        chk("seq_pc", {22'd0, pc}, 3);
        chk("seq_fetch_next", {31'd0, mem_en}, 1);
        wait_halt("halt_reached");
        chk("halt_pc", {22'd0, pc}, 7);
        chk("halt_icount", {16'd0, icount}, 7);
        repeat (20) @(posedge clk);
        #1;
        chk("halt_hold", {29'd0, halted, exec, mem_en}, 3'b100);
        chk("halt_frozen", {6'd0, opcode, pc, icount[9:0]}, {6'd0, 6'h3F, 10'd7, 10'd7});

        // Wrap at 3FF with a pause during LOAD
        do_reset();
        mem[0] = 16'h27FF; mem[10'h3FF] = 16'h0801;
        fetch_q = '{10'd0, 10'h3FF, 10'd0};
        exec_q  = '{16'h27FF, 16'h0801, 16'hFC00};
        @(negedge clk) reset = 1'b1;
        @(negedge clk) run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 10'h3FF) begin seen = 1'b1; break; end
        end
        chk("wrap_fetch_seen", {31'd0, seen}, 1);
        @(posedge clk);
        #1 run = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pause_pc_wrapped", {22'd0, pc}, 0);
        chk("pause_icount", {16'd0, icount}, 2);
        chk("pause_idle", {29'd0, exec, mem_en, halted}, 0);
        chk("pause_no_fetch", fetch_q.size(), 1);
        mem[0] = 16'hFC00;
        @(negedge clk) run = 1'b1;
        wait_halt("resume_halt");
        chk("resume_pc", {22'd0, pc}, 0);
        chk("resume_icount", {16'd0, icount}, 3);

        // Asynchronous reset mid-EXEC
        do_reset();
        mem[0] = 16'h0401;
        fetch_q = '{10'd0};
        exec_q  = '{16'h0401};
        @(negedge clk) reset = 1'b1;
        @(negedge clk) run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exec) begin seen = 1'b1; break; end
        end
        chk("areset_exec_seen", {31'd0, seen}, 1);
        #1 reset = 1'b0;
        #1;
        chk("areset_outs", {16'd0, opcode, jaddr}, 0);
        chk("areset_flags", {29'd0, exec, mem_en, halted}, 0);
        chk("areset_pc", {22'd0, pc}, 0);
        chk("areset_icount", {16'd0, icount}, 0);
        @(posedge clk);
        #1;
        chk("areset_hold", {6'd0, pc, icount}, 0);

        chk("fetch_q_empty", fetch_q.size(), 0);
        chk("exec_q_empty", exec_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
